uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, next generation of the single-byte transmitter.
- Frame format (data bits, parity, stop bits) and baud divisor are set at elaboration time.
- Words are accepted on a valid/ready handshake into an internal FIFO.
- Frames are sent back-to-back with no idle gap.
- Sits between the system-side producer and the tx pad in the UART subsystem.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_cfg_if.sv | 15 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_cfg.sv | 154 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Contents: parity mode constants, transmitter state encoding,
// rounded baud divisor and bit-counter width helpers.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } tx_state_e;

  // Bit period in clocks, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Width of a counter that indexes data bits 0..data_bits-1.
  function automatic int unsigned bit_cnt_w(input int unsigned data_bits);
    return (data_bits <= 2) ? 1 : $clog2(data_bits);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side word handshake for the UART transmitter.
// tx_data/tx_valid driven by the producer (master), tx_ready by the
// transmitter (slave); a word moves on a rising edge with valid && ready.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and registered ready.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata_c (head word,
// combinational), empty_c, ready (= not full, low in reset), level.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     empty_c,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt_c;

  assign rdata_c = mem[rd_ptr];
  assign empty_c = (level == '0);

  // Occupancy after this edge; push+pop together leaves it unchanged.
  always_comb begin
    level_nxt_c = level;
    if (push && !pop) begin
      level_nxt_c = level + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt_c = level - LVL_W'(1);
    end
  end

  // Storage needs no reset; pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level_nxt_c;
      ready <= (level_nxt_c != LVL_W'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: words enter a FIFO over a valid/ready
// handshake and leave LSB first as start/data/parity/stop frames, back to
// back when the FIFO keeps supplying words.
// Ports: sys_clk_100M, rst (sync, active-high), s_if (word handshake),
// tx (serial line, idle high), busy, tx_done (last cycle of final stop
// bit), fifo_level (FIFO occupancy).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          sys_clk_100M,
  input  logic                          rst,
  uart_tx_cfg_if.slave                  s_if,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned BIT_W  = bit_cnt_w(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_d, done_d, busy_d;
  logic                 baud_last_c;

  logic                 push_c, pop_c;
  logic                 fifo_ready, fifo_empty_c;
  logic [DATA_BITS-1:0] fifo_rdata_c;

  assign push_c        = s_if.tx_valid && fifo_ready;
  assign s_if.tx_ready = fifo_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk_100M),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (s_if.tx_data),
    .rdata_c (fifo_rdata_c),
    .empty_c (fifo_empty_c),
    .ready   (fifo_ready),
    .level   (fifo_level)
  );

  assign baud_last_c = (baud_q == BAUD_W'(DIV - 1));

  // Next-state, counters and line value; tx/tx_done/busy are registered
  // from these, so the line trails the state by one cycle throughout.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    pop_c   = 1'b0;
    busy_d  = (state_q != S_IDLE) || !fifo_empty_c;

    if (state_q != S_IDLE) begin
      baud_d = baud_last_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        pop_c = !fifo_empty_c;
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_last_c) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_last_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        tx_d = par_q;
        if (baud_last_c) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            bit_d   = '0;
            state_d = S_IDLE;
            pop_c   = !fifo_empty_c;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pop always starts a new frame on the next cycle.
    if (pop_c) begin
      shift_d = fifo_rdata_c;
      par_d   = (PARITY == PARITY_ODD) ? ~(^fifo_rdata_c) : (^fifo_rdata_c);
      state_d = S_START;
    end
  end

  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
      tx_done <= done_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations side by side
// (8N1 at 100 MHz/115200, 8E1, 8O1 and 5N2 at divisor 8), a word queue as
// scoreboard, and a serial decoder that checks every bit edge and tx_done.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [4];
  logic [3:0] vld;
  logic [3:0] rdy, txw, bsy, dne;
  logic [3:0][2:0] lvl;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sbq [$];

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if_d ();

  assign if_a.tx_data = din[0];
  assign if_b.tx_data = din[1];
  assign if_c.tx_data = din[2];
  assign if_d.tx_data = din[3][4:0];
  assign if_a.tx_valid = vld[0];
  assign if_b.tx_valid = vld[1];
  assign if_c.tx_valid = vld[2];
  assign if_d.tx_valid = vld[3];
  assign rdy = {if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

  uart_tx_cfg #(.CLK_FREQ(100_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .sys_clk_100M(clk), .rst(rst), .s_if(if_a),
    .tx(txw[0]), .busy(bsy[0]), .tx_done(dne[0]), .fifo_level(lvl[0]));

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(125_000), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .sys_clk_100M(clk), .rst(rst), .s_if(if_b),
    .tx(txw[1]), .busy(bsy[1]), .tx_done(dne[1]), .fifo_level(lvl[1]));

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(125_000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .sys_clk_100M(clk), .rst(rst), .s_if(if_c),
    .tx(txw[2]), .busy(bsy[2]), .tx_done(dne[2]), .fifo_level(lvl[2]));

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(125_000), .DATA_BITS(5),
                .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .sys_clk_100M(clk), .rst(rst), .s_if(if_d),
    .tx(txw[3]), .busy(bsy[3]), .tx_done(dne[3]), .fifo_level(lvl[3]));

  // Expected frame format per instance.
  function automatic int div_of(input int i);
    return (i == 0) ? 868 : 8;
  endfunction
  function automatic int nbits_of(input int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int stop_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a word and hold it until accepted; returns just after the push edge.
  task automatic push_word(input int i, input logic [7:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    din[i] = d;
    vld[i] = 1'b1;
    for (int t = 0; t < 20000 && !done; t++) begin
      if (rdy[i]) begin
        @(posedge clk);
        sbq.push_back(d);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("dut%0d push_accepted", i), 32'(done), 1);
  endtask

  // Decode one frame; ends on the negedge of its last cycle.
  task automatic recv_frame(input int i, input bit immediate);
    int dv, nb, pm, ns, fl, b, pos, ones;
    logic [7:0] exp_d;
    logic exp_tx, par_bit;
    bit found, early;
    dv = div_of(i);
    nb = nbits_of(i);
    pm = par_of(i);
    ns = stop_of(i);
    fl = (1 + nb + ((pm != 0) ? 1 : 0) + ns) * dv;
    found = 1'b0;
    early = 1'b0;
    if (immediate) begin
      @(negedge clk);
      found = (txw[i] == 1'b0);
    end else begin
      for (int t = 0; t < 30000 && !found; t++) begin
        @(negedge clk);
        if (txw[i] == 1'b0) found = 1'b1;
      end
    end
    check($sformatf("dut%0d start_seen", i), 32'(found), 1);
    if (!found) return;
    check($sformatf("dut%0d sb_has_word", i), 32'(sbq.size() != 0), 1);
    exp_d = (sbq.size() != 0) ? sbq.pop_front() : 8'h00;
    ones = 0;
    for (int k = 0; k < nb; k++) ones += int'(exp_d[k]);
    par_bit = (pm == 2) ? ones[0] : ~ones[0];
    for (int c = 1; c <= fl; c++) begin
      if (c > 1) @(negedge clk);
      b   = (c - 1) / dv;
      pos = (c - 1) % dv;
      if (b == 0) exp_tx = 1'b0;
      else if (b <= nb) exp_tx = exp_d[b-1];
      else if (pm != 0 && b == nb + 1) exp_tx = par_bit;
      else exp_tx = 1'b1;
      if (pos == 0 || pos == dv - 1)
        check($sformatf("dut%0d word%0h bit%0d cyc%0d", i, exp_d, b, pos), 32'(txw[i]), 32'(exp_tx));
      if (c < fl && dne[i]) early = 1'b1;
    end
    check($sformatf("dut%0d tx_done_last", i), 32'(dne[i]), 1);
    check($sformatf("dut%0d tx_done_early", i), 32'(early), 0);
  endtask

  initial begin
    bit seen;
    vld = '0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut%0d rst_tx", i), 32'(txw[i]), 1);
      check($sformatf("dut%0d rst_ready", i), 32'(rdy[i]), 0);
      check($sformatf("dut%0d rst_busy", i), 32'(bsy[i]), 0);
      check($sformatf("dut%0d rst_done", i), 32'(dne[i]), 0);
      check($sformatf("dut%0d rst_level", i), 32'(lvl[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("dut%0d ready_after_rst", i), 32'(rdy[i]), 1);

    // 8N1 0x55: line low two edges after the push, then full frame
    push_word(0, 8'h55);
    @(negedge clk);
    vld[0] = 1'b0;
    check("a lat_k1_tx", 32'(txw[0]), 1);
    @(negedge clk);
    check("a lat_k2_tx", 32'(txw[0]), 1);
    check("a busy_early", 32'(bsy[0]), 1);
    recv_frame(0, 1'b1);
    check("a busy_at_done", 32'(bsy[0]), 1);
    @(negedge clk);
    check("a busy_fall", 32'(bsy[0]), 0);
    check("a level_idle", 32'(lvl[0]), 0);

    // Parity, odd/even, and 5-bit/2-stop formats
    push_word(1, 8'h07);
    @(negedge clk);
    vld[1] = 1'b0;
    recv_frame(1, 1'b0);
    push_word(2, 8'h07);
    @(negedge clk);
    vld[2] = 1'b0;
    recv_frame(2, 1'b0);
    push_word(3, 8'h1F);
    @(negedge clk);
    vld[3] = 1'b0;
    recv_frame(3, 1'b0);

    // Six words with valid held: FIFO fills, frames run back to back
    fork
      begin
        for (int w = 1; w <= 6; w++) begin
          push_word(0, 8'(w));
          if (w == 5) begin
            @(negedge clk);
            check("a level_full", 32'(lvl[0]), 4);
            check("a ready_full", 32'(rdy[0]), 0);
          end
        end
        @(negedge clk);
        vld[0] = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) recv_frame(0, f > 0);
      end
    join
    @(negedge clk);
    check("a busy_after_six", 32'(bsy[0]), 0);

    // Push landing on the same edge as a pop at level 2
    fork
      begin
        push_word(1, 8'hA1);
        push_word(1, 8'hA2);
        push_word(1, 8'hA3);
        @(negedge clk);
        vld[1] = 1'b0;
        check("b level_two", 32'(lvl[1]), 2);
        repeat (88 - 2) @(negedge clk);
        din[1] = 8'hA4;
        vld[1] = 1'b1;
        check("b ready_before_pp", 32'(rdy[1]), 1);
        @(negedge clk);
        vld[1] = 1'b0;
        sbq.push_back(8'hA4);
        check("b pop_edge_done", 32'(dne[1]), 1);
        check("b level_pushpop", 32'(lvl[1]), 2);
      end
      begin
        for (int f = 0; f < 4; f++) recv_frame(1, f > 0);
      end
    join
    @(negedge clk);
    check("b busy_after_pp", 32'(bsy[1]), 0);

    // Reset during data bit 3 with two words queued
    push_word(1, 8'hC3);
    push_word(1, 8'h3C);
    push_word(1, 8'h5A);
    @(negedge clk);
    vld[1] = 1'b0;
    check("b rst_start_low", 32'(txw[1]), 0);
    repeat (35) @(negedge clk);
    check("b level_before_rst", 32'(lvl[1]), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("b midrst_tx", 32'(txw[1]), 1);
    check("b midrst_level", 32'(lvl[1]), 0);
    check("b midrst_done", 32'(dne[1]), 0);
    check("b midrst_busy", 32'(bsy[1]), 0);
    seen = 1'b0;
    for (int c = 0; c < 3 * 88; c++) begin
      @(negedge clk);
      if (dne[1] || !txw[1]) seen = 1'b1;
    end
    check("b quiet_after_rst", 32'(seen), 0);
    sbq.delete();
    push_word(1, 8'h96);
    @(negedge clk);
    vld[1] = 1'b0;
    recv_frame(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
